clock_time_ctrl: RTL and testbench

Timekeeping and display controller for the hours/minutes digital clock. It consumes the divider's 1 Hz and 500 Hz outputs as sampled levels in the 50 MHz domain and advances an HH:MM:SS BCD time base. A RUN/SET_HR/SET_MIN state machine is driven by two debounced push-buttons, and the block schedules the 4-digit multiplexed display. It sits between clk_divider and the seven-segment decoder.

---
 rtl/clock_time_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// HH:MM timekeeping core with RUN/SET_HR/SET_MIN control, button debounce
// and 4-digit multiplexed display scheduling for the seven-segment decoder.
module clock_time_ctrl #(
  parameter int         DEBOUNCE_TICKS = 10,
  parameter logic [3:0] BLANK_CODE     = 4'hF
) (
  input  logic       clk_50Mhz,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_500hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic       sec_tick,
  output logic [3:0] digit_sel,
  output logic [3:0] digit_bcd
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] SET_HR  = 2'b01;
  localparam logic [1:0] SET_MIN = 2'b10;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic       sec_p0, sec_p1, sec_p2;
  logic       scan_p0, scan_p1, scan_p2;
  logic       scan_pulse;
  logic [1:0] btn_p0, btn_p1;
  logic [1:0] db_lvl, db_lvl_d;
  logic [7:0] db_cnt [2];
  logic [1:0] press;
  logic       mode_press, inc_press;
  logic [5:0] sec;
  logic [7:0] min_next;
  logic [5:0] hour_next;
  logic [1:0] idx;
  logic [3:0] digit_val;
  logic       blank;

  // Returns {carry, tens, ones} for a 00..59 minute field.
  function automatic logic [7:0] inc_min(input logic [2:0] t, input logic [3:0] o);
    if (o != 4'd9)      inc_min = {1'b0, t, o + 4'd1};
    else if (t != 3'd5) inc_min = {1'b0, t + 3'd1, 4'd0};
    else                inc_min = 8'h80;
  endfunction

  function automatic logic [5:0] inc_hour(input logic [1:0] t, input logic [3:0] o);
    if (t == 2'd2 && o == 4'd3) inc_hour = 6'd0;
    else if (o == 4'd9)         inc_hour = {t + 2'd1, 4'd0};
    else                        inc_hour = {t, o + 4'd1};
  endfunction

  assign min_next   = inc_min(min_tens, min_ones);
  assign hour_next  = inc_hour(hour_tens, hour_ones);
  assign press      = db_lvl & ~db_lvl_d;
  assign mode_press = press[0];
  assign inc_press  = press[1] & ~press[0];

  // Stage: synchronisers and registered rising-edge pulses
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      sec_p0 <= 1'b0; sec_p1 <= 1'b0; sec_p2 <= 1'b0; sec_tick <= 1'b0;
      scan_p0 <= 1'b0; scan_p1 <= 1'b0; scan_p2 <= 1'b0; scan_pulse <= 1'b0;
    end else begin
      sec_p0   <= clk_1hz;   sec_p1  <= sec_p0;  sec_p2  <= sec_p1;
      scan_p0  <= clk_500hz; scan_p1 <= scan_p0; scan_p2 <= scan_p1;
      sec_tick   <= sec_p1 & ~sec_p2;
      scan_pulse <= scan_p1 & ~scan_p2;
    end
  end

  // Stage: button debounce, bit 0 = mode, bit 1 = inc
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      btn_p0   <= 2'b00;
      btn_p1   <= 2'b00;
      db_lvl   <= 2'b00;
      db_lvl_d <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= 8'd0;
    end else begin
      btn_p0   <= {btn_inc, btn_mode};
      btn_p1   <= btn_p0;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (btn_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (scan_pulse) begin
          if (db_cnt[i] == DB_LAST) begin
            db_lvl[i] <= btn_p1[i];
            db_cnt[i] <= 8'd0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Stage: mode FSM and time base
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      mode      <= RUN;
      sec       <= 6'd0;
      min_tens  <= 3'd0;
      min_ones  <= 4'd0;
      hour_tens <= 2'd0;
      hour_ones <= 4'd0;
    end else begin
      if (mode_press) begin
        case (mode)
          RUN:     mode <= SET_HR;
          SET_HR:  mode <= SET_MIN;
          SET_MIN: begin
            mode <= RUN;
            sec  <= 6'd0;
          end
          default: mode <= RUN;
        endcase
      end else if (inc_press) begin
        if (mode == SET_HR)  {hour_tens, hour_ones} <= hour_next;
        if (mode == SET_MIN) {min_tens, min_ones}   <= min_next[6:0];
      end
      if (mode == RUN && sec_tick) begin
        if (sec == 6'd59) begin
          sec <= 6'd0;
          {min_tens, min_ones} <= min_next[6:0];
          if (min_next[7]) {hour_tens, hour_ones} <= hour_next;
        end else begin
          sec <= sec + 6'd1;
        end
      end
    end
  end

  always_comb begin
    digit_val = 4'd0;
    case (idx)
      2'd0: digit_val = min_ones;
      2'd1: digit_val = {1'b0, min_tens};
      2'd2: digit_val = hour_ones;
      2'd3: digit_val = {2'b00, hour_tens};
      default: digit_val = 4'd0;
    endcase
  end

  // The field being edited flashes with the synced 1 Hz level.
  assign blank = sec_p1 && ((mode == SET_HR && idx[1]) || (mode == SET_MIN && !idx[1]));

  // Stage: display scan
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      idx       <= 2'd0;
      digit_sel <= 4'b0001;
      digit_bcd <= 4'd0;
    end else begin
      if (scan_pulse) idx <= idx + 2'd1;
      digit_sel <= 4'b0001 << idx;
      digit_bcd <= blank ? BLANK_CODE : digit_val;
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with a short debounce so button
// presses can set the time quickly.
module tb_clock_time_ctrl;

  logic       clk_50Mhz = 1'b0;
  logic       rst, clk_1hz, clk_500hz, btn_mode, btn_inc;
  logic [1:0] mode, hour_tens;
  logic [3:0] hour_ones, min_ones, digit_sel, digit_bcd;
  logic [2:0] min_tens;
  logic       sec_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int scans  = 0;
  int tick_cnt = 0;

  clock_time_ctrl #(.DEBOUNCE_TICKS(2), .BLANK_CODE(4'hF)) dut (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .clk_1hz(clk_1hz), .clk_500hz(clk_500hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .mode(mode),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tick(sec_tick), .digit_sel(digit_sel),
    .digit_bcd(digit_bcd)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  always @(posedge clk_50Mhz) if (sec_tick) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50Mhz);
    #1;
  endtask

  task automatic scan();
    clk_500hz = 1'b1; cyc(4);
    clk_500hz = 1'b0; cyc(4);
    scans++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      clk_1hz = 1'b1; cyc(4);
      clk_1hz = 1'b0; cyc(4);
    end
  endtask

  // which: 0 = mode, 1 = inc, 2 = both together
  task automatic press(input int which, input int n);
    repeat (n) begin
      btn_mode = (which != 1);
      btn_inc  = (which != 0);
      repeat (3) scan();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (3) scan();
    end
  endtask

  function automatic logic [15:0] hhmm();
    hhmm = {2'b00, hour_tens, hour_ones, 1'b0, min_tens, min_ones};
  endfunction

  initial begin
    logic [3:0] exp_bcd [4];
    logic [3:0] one;
    one = 4'b0001;
    rst = 1'b1; clk_1hz = 1'b0; clk_500hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(2);
    chk("rst_mode", 16'(mode), 16'h0);
    chk("rst_time", hhmm(), 16'h0000);
    chk("rst_sel", 16'(digit_sel), 16'h1);
    rst = 1'b0; cyc(2);

    // Bouncy mode button: alternating levels must never reach the threshold.
    for (int i = 0; i < 6; i++) begin
      btn_mode = (i % 2 == 0);
      scan();
    end
    chk("bounce_mode", 16'(mode), 16'h0);
    btn_mode = 1'b1; scan(); scan();
    chk("hold_mode", 16'(mode), 16'h1);
    btn_mode = 1'b0; repeat (3) scan();
    chk("release_mode", 16'(mode), 16'h1);

    press(1, 10);
    chk("hr_10", hhmm(), 16'h1000);
    press(1, 13);
    chk("hr_23", hhmm(), 16'h2300);
    press(1, 1);
    chk("hr_wrap", hhmm(), 16'h0000);
    press(1, 23);
    press(0, 1);
    chk("mode_setmin", 16'(mode), 16'h2);
    press(1, 59);
    chk("min_59", hhmm(), 16'h2359);
    press(1, 1);
    chk("min_wrap", hhmm(), 16'h2300);
    press(1, 59);
    press(2, 1);
    chk("both_mode", 16'(mode), 16'h0);
    chk("both_time", hhmm(), 16'h2359);
    press(1, 1);
    chk("run_inc_ign", hhmm(), 16'h2359);

    // Seconds restart at 0 on leaving SET_MIN.
    tick(58);
    chk("sec58", hhmm(), 16'h2359);
    tick_cnt = 0;
    tick(1);
    chk("sec59", hhmm(), 16'h2359);
    tick(1);
    chk("rollover", hhmm(), 16'h0000);
    chk("tick_cnt", 16'(tick_cnt), 16'd2);
    tick(59);
    chk("min0_hold", hhmm(), 16'h0000);
    tick(1);
    chk("min1", hhmm(), 16'h0001);

    press(0, 1);
    press(1, 21);
    press(0, 1);
    press(1, 46);
    press(0, 1);
    chk("set_2147", hhmm(), 16'h2147);
    chk("mode_run", 16'(mode), 16'h0);
    exp_bcd[0] = 4'd7; exp_bcd[1] = 4'd4; exp_bcd[2] = 4'd1; exp_bcd[3] = 4'd2;
    for (int i = 0; i < 8; i++) begin
      scan();
      chk("scan_sel", 16'(digit_sel), 16'(one << (scans % 4)));
      chk("scan_bcd", 16'(digit_bcd), 16'(exp_bcd[scans % 4]));
    end

    press(0, 1);
    chk("mode_sethr", 16'(mode), 16'h1);
    clk_1hz = 1'b1; cyc(4);
    exp_bcd[2] = 4'hF; exp_bcd[3] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      scan();
      chk("blank_sel", 16'(digit_sel), 16'(one << (scans % 4)));
      chk("blank_bcd", 16'(digit_bcd), 16'(exp_bcd[scans % 4]));
    end
    chk("blank_time", hhmm(), 16'h2147);
    clk_1hz = 1'b0; cyc(4);

    press(1, 15);
    press(0, 1);
    press(1, 47);
    press(0, 1);
    tick(56);
    chk("pre_rst", hhmm(), 16'h1234);
    rst = 1'b1; cyc(2);
    rst = 1'b0; scans = 0;
    chk("mid_rst_mode", 16'(mode), 16'h0);
    chk("mid_rst_time", hhmm(), 16'h0000);
    chk("mid_rst_sel", 16'(digit_sel), 16'h1);
    chk("mid_rst_bcd", 16'(digit_bcd), 16'h0);
    chk("mid_rst_tick", 16'(sec_tick), 16'h0);
    tick(59);
    chk("rst_sec_hold", hhmm(), 16'h0000);
    tick(1);
    chk("rst_sec_zero", hhmm(), 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
